// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl: tile sequencer for a SIZE x SIZE systolic array.
// Accepts KLEN beats of weight/input rows, feeds them to the array with
// per-lane diagonal skew, waits for the pipeline to drain, then captures
// and presents the column results over a valid/ready port.
// Optional build macro: SYSTOLIC_TILE_PERF_EN adds perf_stall/perf_cycles.
module systolic_tile_ctrl #(
  parameter int SIZE      = 4,
  parameter int KLEN      = 4,
  parameter int DRAIN_CYC = 12,
  parameter int BUSW      = SIZE + 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*SIZE-1:0]    in_weight,
  input  logic [8*SIZE-1:0]    in_data,
  output logic [8*SIZE-1:0]    arr_weight,
  output logic [8*SIZE-1:0]    arr_in,
  input  logic [SIZE*BUSW-1:0] arr_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SIZE*BUSW-1:0] res_data,
  output logic                 done
`ifdef SYSTOLIC_TILE_PERF_EN
  ,
  output logic [15:0]          perf_stall,
  output logic [15:0]          perf_cycles
`endif
);

  localparam int CMAX1 = (KLEN > SIZE) ? KLEN : SIZE;
  localparam int CMAX  = (CMAX1 > DRAIN_CYC) ? CMAX1 : DRAIN_CYC;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] BEAT_LAST  = CW'(KLEN - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]    state, state_next;
  // One counter serves as beat, flush and drain count; each phase restarts it.
  logic [CW-1:0] cnt, cnt_next;
  logic          capture;
  logic          accept;

  assign accept = in_valid & in_ready;

  // Next-state and phase-counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
          cnt_next   = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (cnt == BEAT_LAST) begin
            state_next = S_FLUSH;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          state_next = S_DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_next = S_HOLD;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, registered status outputs and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      res_data  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      in_ready  <= (state_next == S_LOAD);
      busy      <= (state_next != S_IDLE);
      res_valid <= (state_next == S_HOLD);
      done      <= (state == S_HOLD) && res_ready;
      if (capture) res_data <= arr_result;
    end
  end

  // Per-lane skew: lane gi has gi delay stages plus the output stage, so an
  // accepted byte reaches the array bus 1+gi cycles later. Zeros fill gaps.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
    localparam int D = 8 * (gi + 1);
    logic [D-1:0] w_sr, d_sr;
    logic [7:0]   w_new, d_new;

    assign w_new = accept ? in_weight[8*gi +: 8] : 8'h00;
    assign d_new = accept ? in_data[8*gi +: 8]   : 8'h00;

    if (gi == 0) begin : g_first
      // Lane 0 has only the output stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          w_sr <= '0;
          d_sr <= '0;
        end else begin
          w_sr <= w_new;
          d_sr <= d_new;
        end
      end
    end else begin : g_rest
      // Shift the lane chain toward the output stage at the top byte.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          w_sr <= '0;
          d_sr <= '0;
        end else begin
          w_sr <= {w_sr[D-9:0], w_new};
          d_sr <= {d_sr[D-9:0], d_new};
        end
      end
    end

    assign arr_weight[8*gi +: 8] = w_sr[D-1 -: 8];
    assign arr_in[8*gi +: 8]     = d_sr[D-1 -: 8];
  end

`ifdef SYSTOLIC_TILE_PERF_EN
  logic stall_cyc;
  assign stall_cyc = ((state == S_LOAD) && !in_valid) ||
                     ((state == S_HOLD) && !res_ready);

  // Saturating performance counters, cleared when a tile is started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall  <= '0;
      perf_cycles <= '0;
    end else if ((state == S_IDLE) && start) begin
      perf_stall  <= '0;
      perf_cycles <= '0;
    end else if (state != S_IDLE) begin
      if (perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
      if (stall_cyc && (perf_stall != 16'hFFFF)) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Directed testbench for systolic_tile_ctrl (default parameters).
module tb_systolic_tile_ctrl;
  localparam int SIZE      = 4;
  localparam int KLEN      = 4;
  localparam int DRAIN_CYC = 12;
  localparam int BUSW      = SIZE + 16;
  localparam int RW        = SIZE * BUSW;
  localparam int LAT       = KLEN + SIZE + DRAIN_CYC;

  localparam logic [RW-1:0] PAT  = 80'h0123_4567_89ab_cdef_1357;
  localparam logic [RW-1:0] PAT2 = 80'hfedc_ba98_7654_3210_2468;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [8*SIZE-1:0] in_weight;
  logic [8*SIZE-1:0] in_data;
  logic [8*SIZE-1:0] arr_weight;
  logic [8*SIZE-1:0] arr_in;
  logic [RW-1:0]     arr_result;
  logic              res_valid;
  logic              res_ready;
  logic [RW-1:0]     res_data;
  logic              done;
`ifdef SYSTOLIC_TILE_PERF_EN
  logic [15:0]       perf_stall;
  logic [15:0]       perf_cycles;
`endif

  int checks = 0;
  int errors = 0;

  systolic_tile_ctrl #(
    .SIZE(SIZE), .KLEN(KLEN), .DRAIN_CYC(DRAIN_CYC), .BUSW(BUSW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_weight(in_weight), .in_data(in_data),
    .arr_weight(arr_weight), .arr_in(arr_in), .arr_result(arr_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .done(done)
`ifdef SYSTOLIC_TILE_PERF_EN
    , .perf_stall(perf_stall), .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a tile up to res_valid. Bubbles are inserted once beat bub_at is due.
  // lat counts edges from the first acceptance edge (inclusive) to res_valid.
  task automatic run_tile(input int bub_at, input int nbub, input logic hold_start,
                          output int lat, output int acc);
    int b = 0;
    int left = nbub;
    bit started = 0;
    lat = 0;
    acc = 0;
    start = 1'b1;
    tick();
    start = hold_start;
    for (int n = 0; n < 200; n++) begin
      if (b == bub_at && left > 0) begin
        in_valid = 1'b0;
        left--;
      end else begin
        in_valid = 1'b1;
      end
      in_weight = {4{8'(b + 1)}};
      in_data   = {4{8'(b + 8'h40)}};
      if (in_valid && in_ready) begin
        acc++;
        b++;
        started = 1;
      end
      tick();
      if (started) lat++;
      if (res_valid) break;
    end
    in_valid  = 1'b0;
    in_weight = '0;
    in_data   = '0;
  endtask

  // Completes the result handshake and checks the done pulse.
  task automatic finish_hs(input string tag);
    res_ready = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_vld0"}, res_valid, 1'b0);
    check({tag, "_busy0"}, busy, 1'b0);
    tick();
    check({tag, "_done0"}, done, 1'b0);
  endtask

  initial begin
    int lat, acc, n;
    logic [31:0] exp_w [5];
    logic [31:0] exp_d [5];
    exp_w[0] = 32'h0000_0011; exp_d[0] = 32'h0000_00aa;
    exp_w[1] = 32'h0000_2200; exp_d[1] = 32'h0000_bb00;
    exp_w[2] = 32'h0033_0000; exp_d[2] = 32'h00cc_0000;
    exp_w[3] = 32'h4400_0000; exp_d[3] = 32'hdd00_0000;
    exp_w[4] = 32'h0000_0000; exp_d[4] = 32'h0000_0000;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_weight = '0; in_data = '0;
    arr_result = PAT; res_ready = 1'b1;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_arr_weight", arr_weight, '0);
    check("rst_arr_in", arr_in, '0);
    check("rst_res_data", res_data, '0);
`ifdef SYSTOLIC_TILE_PERF_EN
    check("rst_perf_stall", perf_stall, 16'd0);
    check("rst_perf_cycles", perf_cycles, 16'd0);
`endif
    rst = 1'b0;
    tick();

    // Skew: one beat then bubbles, lane i appears 1+i cycles after acceptance.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("skew_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_weight = 32'h4433_2211; in_data = 32'hddcc_bbaa;
    tick();
    in_valid = 1'b0; in_weight = '0; in_data = '0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      check($sformatf("skew_w_t%0d", k + 1), arr_weight, exp_w[k]);
      check($sformatf("skew_d_t%0d", k + 1), arr_in, exp_d[k]);
    end
    in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
    check("skew_res_valid", res_valid, 1'b1);
    check("skew_res_data", res_data, PAT);
    finish_hs("skew");
`ifdef SYSTOLIC_TILE_PERF_EN
    check("skew_perf_stall", perf_stall, 16'd4);
    check("skew_perf_cycles", perf_cycles, 16'd25);
`endif

    // Back-to-back tile without bubbles.
    run_tile(99, 0, 1'b0, lat, acc);
    check("b2b_latency", lat, LAT);
    check("b2b_accepts", acc, KLEN);
    check("b2b_res_data", res_data, PAT);
    check("b2b_busy", busy, 1'b1);
    check("b2b_done_pre", done, 1'b0);
    finish_hs("b2b");
`ifdef SYSTOLIC_TILE_PERF_EN
    check("b2b_perf_stall", perf_stall, 16'd0);
    check("b2b_perf_cycles", perf_cycles, 16'd21);
`endif

    // Three bubbles between beats 1 and 2.
    run_tile(2, 3, 1'b0, lat, acc);
    check("bub_latency", lat, LAT + 3);
    check("bub_accepts", acc, KLEN);
    finish_hs("bub");
`ifdef SYSTOLIC_TILE_PERF_EN
    check("bub_perf_stall", perf_stall, 16'd3);
    check("bub_perf_cycles", perf_cycles, 16'd24);
`endif

    // Backpressure in HOLD with start pulses.
    res_ready = 1'b0;
    run_tile(99, 0, 1'b0, lat, acc);
    check("bp_latency", lat, LAT);
    arr_result = PAT2;
    for (int k = 0; k < 5; k++) begin
      start = 1'b1;
      tick();
      check($sformatf("bp_data_%0d", k), res_data, PAT);
      check($sformatf("bp_vld_%0d", k), res_valid, 1'b1);
      check($sformatf("bp_busy_%0d", k), busy, 1'b1);
      check($sformatf("bp_done_%0d", k), done, 1'b0);
    end
    finish_hs("bp");
    check("bp_no_restart", busy, 1'b0);
`ifdef SYSTOLIC_TILE_PERF_EN
    check("bp_perf_stall", perf_stall, 16'd5);
    check("bp_perf_cycles", perf_cycles, 16'd26);
`endif
    arr_result = PAT;

    // Start held high through LOAD/FLUSH/DRAIN must not disturb the tile.
    run_tile(99, 0, 1'b1, lat, acc);
    check("st_latency", lat, LAT);
    check("st_accepts", acc, KLEN);
    check("st_res_data", res_data, PAT);
    finish_hs("st");

    // Reset after 2 of 4 beats, then a clean tile.
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_weight = 32'h5566_7788; in_data = 32'h1122_3344;
    tick(); tick();
    #1 rst = 1'b1;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_in_ready", in_ready, 1'b0);
    check("mrst_arr_weight", arr_weight, '0);
    check("mrst_arr_in", arr_in, '0);
    check("mrst_res_valid", res_valid, 1'b0);
    in_valid = 1'b0; in_weight = '0; in_data = '0;
    rst = 1'b0;
    tick();
    check("mrst_idle", busy, 1'b0);
    arr_result = PAT2;
    run_tile(99, 0, 1'b0, lat, acc);
    check("mrst_latency", lat, LAT);
    check("mrst_accepts", acc, KLEN);
    check("mrst_res_data", res_data, PAT2);
    finish_hs("mrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
